// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between an initiator and the data memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with one outstanding load/store, a fixed number of wait states
// and a held response.
//   state  | meaning
//   S_IDLE | ready for a request
//   S_WAIT | request registered, wait-state down-counter running
//   S_RESP | response presented and held until rsp_ready
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          enter_resp;
    logic          mem_wr;
    logic          cur_we;
    logic          cur_err;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] cur_idx;

    // With no wait states the memory access happens on the accept edge, so use the live inputs.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end
        cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH_WORDS));
        cur_idx = cur_addr[AW+1:2];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_we || cur_err) ? 32'h0 : mem[cur_idx];
        end
        mem_wr = enter_resp && cur_we && !cur_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not cleared by reset; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (!rst && mem_wr) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a 2-wait-state instance and a zero-wait instance.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] mm [2][256];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    assign bus0.rsp_ready = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference memory: returns {err, rdata} and applies valid stores.
    function automatic logic [32:0] model_access(input int sel, input bit we, input logic [31:0] addr,
                                                 input logic [31:0] wdata, input int depth);
        logic err;
        err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(depth));
        if (err) return {1'b1, 32'h0};
        if (we) begin
            mm[sel][addr[9:2]] = wdata;
            return {1'b0, 32'h0};
        end
        return {1'b0, mm[sel][addr[9:2]]};
    endfunction

    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic [32:0] exp;
        logic [32:0] first;
        int n;
        @(negedge clk);
        check_eq("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = (hold == 0);
        exp_q.push_back(model_access(0, we, addr, wdata, 256));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = addr ^ 32'hFFFF_FFF0;
        bus.req_wdata = ~wdata;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) break;
        end
        check_eq("latency", n, 3);
        if (!bus.rsp_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        check_eq("req_ready_resp", bus.req_ready, 0);
        if (hold > 0) begin
            first         = {bus.rsp_err, bus.rsp_rdata};
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_addr  = 32'h0;
            bus.req_wdata = 32'hBAD0_0000;
            repeat (hold) begin
                @(negedge clk);
                check_eq("hold_stable", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, first});
                check_eq("hold_req_ready", bus.req_ready, 0);
            end
            bus.rsp_ready = 1'b1;
        end
        exp = exp_q.pop_front();
        check_eq("rsp_data", {bus.rsp_err, bus.rsp_rdata}, exp);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("rsp_idle", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 34'h0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] exp;
        int t_prev;
        logic [31:0] b_addr [8];
        logic [31:0] b_data [8];
        bit          b_we   [8];

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = 32'h0;
        bus0.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_state", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 34'h0});
        check_eq("reset_state0", {bus0.req_ready, bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata}, {1'b1, 34'h0});

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        txn(1'b0, 32'h10, 32'h0, 0);
        txn(1'b1, 32'h0, 32'h1111_1111, 0);
        txn(1'b0, 32'h12, 32'h0, 0);
        txn(1'b0, 32'h400, 32'h0, 0);
        txn(1'b1, 32'h400, 32'h5555_AAAA, 0);
        txn(1'b1, 32'h13, 32'h7777_7777, 0);
        txn(1'b0, 32'h10, 32'h0, 0);
        txn(1'b1, 32'h3FC, 32'hA5A5_5A5A, 0);
        txn(1'b0, 32'h3FC, 32'h0, 0);
        txn(1'b1, 32'h20, 32'hCAFE_F00D, 0);
        txn(1'b0, 32'h20, 32'h0, 5);
        txn(1'b0, 32'h0, 32'h0, 0);

        // Reset while a store sits in WAIT must drop the store.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("wait_outputs", {bus.req_ready, bus.rsp_valid}, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_idle", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {1'b1, 34'h0});
        txn(1'b0, 32'h20, 32'h0, 0);

        // Zero-wait instance, back-to-back requests with rsp_ready tied high.
        b_we   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        b_addr = '{32'h0, 32'h4, 32'h3C, 32'h4, 32'h0, 32'h40, 32'h4, 32'h3C};
        b_data = '{32'h0102_0304, 32'hFFFF_0000, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h0};
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("b2b_ready", bus0.req_ready, 1);
            bus0.req_valid = 1'b1;
            bus0.req_we    = b_we[i];
            bus0.req_addr  = b_addr[i];
            bus0.req_wdata = b_data[i];
            exp_q.push_back(model_access(1, b_we[i], b_addr[i], b_data[i], 16));
            @(posedge clk);
            @(negedge clk);
            check_eq("b2b_valid", {bus0.rsp_valid, bus0.req_ready}, 2'b10);
            exp = exp_q.pop_front();
            check_eq("b2b_data", {bus0.rsp_err, bus0.rsp_rdata}, exp);
            if (i > 0) check_eq("b2b_spacing", cyc - t_prev, 2);
            t_prev = cyc;
        end
        @(negedge clk);
        bus0.req_valid = 1'b0;

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 16..4096).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request accept and response (0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store (MemWrite), 0 = load (MemRead).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator accepts response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge with req_valid=1 and req_ready=1.
REQ-016 On accept, req_we, req_addr and req_wdata SHALL be registered; later input changes have no effect on that transaction.
REQ-017 IDLE->WAIT on accept when WAIT_CYCLES>0; IDLE->RESP on accept when WAIT_CYCLES=0.
REQ-018 In WAIT, a 4-bit counter SHALL count WAIT_CYCLES edges, then go to RESP; rsp_valid therefore rises exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-019 Error condition: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; rsp_err=1, rsp_rdata=0, no array write.
REQ-020 A valid store SHALL write the array word addr[31:2] on the edge entering RESP; a load SHALL register the word on the same edge into rsp_rdata.
REQ-021 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1; on that edge go to IDLE.
REQ-022 No new request SHALL be accepted in the cycle rsp_ready completes a response (req_ready stays 0 until IDLE is registered), giving at most one outstanding transaction.
REQ-023 rsp_valid SHALL be 0 in IDLE and WAIT; rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-024 A load immediately following a store to the same word SHALL return the stored data.
REQ-025 Stores SHALL write all 32 bits; sub-word access is not supported.

Reset
REQ-026 With rst=1 at an edge: state=IDLE, counter=0, req_ready=1 on the next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 Reset SHALL take priority over every other event, including a simultaneous accept or response handshake.
REQ-028 Reset in WAIT SHALL abort the transaction; a pending store SHALL NOT be written.
REQ-029 Array contents SHALL NOT be cleared by reset.

Verification
REQ-030 Store 0xDEADBEEF to 0x10, then load 0x10 with WAIT_CYCLES=2 -> load rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-031 Load from 0x12 (misaligned) and from 4*DEPTH_WORDS (out of range) -> rsp_err=1, rsp_rdata=0; a following load of word 0x10 is unchanged.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; req_valid ignored.
REQ-033 Assert rst during WAIT of a store of 0x12345678 to 0x20 -> IDLE next cycle, outputs 0; a later load of 0x20 returns the prior value.
REQ-034 WAIT_CYCLES=0 with back-to-back requests and rsp_ready tied 1 -> one response every 2 cycles, order preserved, correct data.
REQ-035 Change req_addr and req_wdata during WAIT -> response reflects the values registered at accept.
